// File: rtl/key_debounce_scan.sv
// Synchroniser, debouncer and press/release/auto-repeat event generator for push buttons.
// Each key runs in its own key_debounce_chan instance. The channels share no state.

module key_debounce_chan #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000,
  parameter bit RPT_EN          = 1'b0,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic down,
  output logic up,
  output logic rpt
);
  localparam int DW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] DLAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HDELAY  = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] HPERIOD = HW'(REPEAT_PERIOD);
  localparam logic [HW-1:0] HONE    = HW'(1);

  localparam logic [1:0] RELEASED  = 2'd0;
  localparam logic [1:0] HELD_WAIT = 2'd1;
  localparam logic [1:0] HELD_RPT  = 2'd2;

  logic          s1, s2;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic [1:0]    state;
  logic          accept;

  assign accept = (s2 != level) && (dcnt == DLAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      dcnt  <= '0;
      hcnt  <= '0;
      state <= RELEASED;
      down  <= 1'b0;
      up    <= 1'b0;
      rpt   <= 1'b0;
    end else begin
      s1   <= raw ^ ACTIVE_LOW;
      s2   <= s1;
      down <= 1'b0;
      up   <= 1'b0;
      rpt  <= 1'b0;

      if (s2 == level)  dcnt <= '0;
      else if (accept) begin
        dcnt  <= '0;
        level <= s2;
      end else          dcnt <= dcnt + DW'(1);

      // hcnt counts edges since key_down; an accepted release always wins over a due repeat.
      case (state)
        RELEASED: begin
          if (accept) begin
            down  <= 1'b1;
            hcnt  <= HONE;
            state <= HELD_WAIT;
          end
        end
        HELD_WAIT: begin
          if (accept) begin
            up    <= 1'b1;
            hcnt  <= '0;
            state <= RELEASED;
          end else if (hcnt == HDELAY) begin
            // Keys without repeat park here with hcnt saturated.
            rpt   <= RPT_EN;
            hcnt  <= RPT_EN ? HONE : hcnt;
            state <= RPT_EN ? HELD_RPT : HELD_WAIT;
          end else begin
            hcnt <= hcnt + HONE;
          end
        end
        HELD_RPT: begin
          if (accept) begin
            up    <= 1'b1;
            hcnt  <= '0;
            state <= RELEASED;
          end else if (hcnt == HPERIOD) begin
            rpt  <= 1'b1;
            hcnt <= HONE;
          end else begin
            hcnt <= hcnt + HONE;
          end
        end
        default: begin
          hcnt  <= '0;
          state <= RELEASED;
        end
      endcase
    end
  end
endmodule

module key_debounce_scan #(
  parameter int                 NUM_KEYS        = 2,
  parameter int                 DEBOUNCE_CYCLES = 50000,
  parameter int                 REPEAT_DELAY    = 500000,
  parameter int                 REPEAT_PERIOD   = 100000,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK    = 2'b10,
  parameter bit                 ACTIVE_LOW      = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_up,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic [NUM_KEYS-1:0] key_press
);
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .RPT_EN          (REPEAT_MASK[k]),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_chan (
      .clock (clock),
      .reset (reset),
      .raw   (key_raw[k]),
      .level (key_level[k]),
      .down  (key_down[k]),
      .up    (key_up[k]),
      .rpt   (key_repeat[k])
    );
  end

  assign key_press = key_down | key_repeat;
endmodule

// File: tb/tb_key_debounce_scan.sv
// Directed bench for key_debounce_scan.
// A window/arithmetic reference model is compared on every cycle, and literal checks pin the key timings.

module tb_key_debounce_scan;
  localparam int         NK   = 2;
  localparam int         D    = 4;
  localparam int         RD   = 10;
  localparam int         RP   = 5;
  localparam logic [1:0] MASK = 2'b10;

  logic          clock, reset;
  logic [NK-1:0] key_raw, key_level, key_down, key_up, key_repeat, key_press;

  key_debounce_scan #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .REPEAT_MASK(MASK), .ACTIVE_LOW(1'b0)
  ) dut (
    .clock(clock), .reset(reset), .key_raw(key_raw), .key_level(key_level),
    .key_down(key_down), .key_up(key_up), .key_repeat(key_repeat), .key_press(key_press)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  // Reference model: a level is accepted once the last D raw samples
  // (ending two edges back, through the synchroniser) all disagree with it.
  // A repeat is due RD + n*RP edges after the press.
  logic [NK-1:0] q[$];
  logic [NK-1:0] m_lvl, m_down, m_up, m_rpt;
  int            tp[NK];
  int            ecnt = 0;
  bit            mvalid = 0;

  task automatic model_step();
    bit stable;
    int d;
    ecnt++;
    m_down = '0; m_up = '0; m_rpt = '0;
    if (reset) begin
      q.delete();
      for (int i = 0; i < D + 2; i++) q.push_back('0);
      m_lvl  = '0;
      mvalid = 1;
    end else if (mvalid) begin
      q.push_back(key_raw);
      void'(q.pop_front());
      for (int k = 0; k < NK; k++) begin
        stable = 1;
        for (int j = 0; j < D; j++) if (q[j][k] == m_lvl[k]) stable = 0;
        if (stable) begin
          if (!m_lvl[k]) begin m_down[k] = 1'b1; tp[k] = ecnt; end
          else m_up[k] = 1'b1;
          m_lvl[k] = ~m_lvl[k];
        end else if (m_lvl[k] && MASK[k]) begin
          d = ecnt - tp[k];
          if (d >= RD && (d - RD) % RP == 0) m_rpt[k] = 1'b1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (mvalid) begin
      chk("m_level",  key_level,  m_lvl);
      chk("m_down",   key_down,   m_down);
      chk("m_up",     key_up,     m_up);
      chk("m_repeat", key_repeat, m_rpt);
      chk("m_press",  key_press,  m_down | m_rpt);
    end
  end

  task automatic w(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; key_raw = '0;
    w(3);
    chk("rst_level", key_level, 2'b00);
    chk("rst_down",  key_down,  2'b00);
    chk("rst_up",    key_up,    2'b00);
    reset = 1'b0;
    w(2);

    // key 0 press: key_down exactly after the 6th edge, never repeats
    key_raw = 2'b01; w(5);
    chk("t1_early_down", key_down, 2'b00);
    w(1);
    chk("t1_down",  key_down,  2'b01);
    chk("t1_level", key_level, 2'b01);
    w(1);
    chk("t1_down_end", key_down, 2'b00);
    w(30);
    chk("t1_norpt", key_repeat, 2'b00);
    key_raw = 2'b00; w(10);

    // glitch of D-1 samples is rejected
    key_raw = 2'b01; w(3); key_raw = 2'b00; w(10);
    chk("t2_level", key_level, 2'b00);

    // exactly D samples is accepted
    key_raw = 2'b01; w(4); key_raw = 2'b00; w(2);
    chk("bd_down", key_down, 2'b01);
    w(12);

    // key 1 auto-repeat, then release landing on a due repeat
    key_raw = 2'b10; w(6);
    chk("t3_down", key_down, 2'b10);
    w(10);
    chk("t3_rpt1",  key_repeat, 2'b10);
    chk("t3_press", key_press,  2'b10);
    w(5);
    chk("t3_rpt2", key_repeat, 2'b10);
    w(4);
    key_raw = 2'b00; w(1);
    chk("t3_rpt3", key_repeat, 2'b10);
    w(5);
    chk("t4_up",    key_up,     2'b10);
    chk("t4_norpt", key_repeat, 2'b00);
    w(20);

    // simultaneous press, single release
    key_raw = 2'b11; w(6);
    chk("t5_down", key_down, 2'b11);
    w(3);
    key_raw = 2'b10; w(6);
    chk("t5_up", key_up, 2'b01);
    key_raw = 2'b00; w(12);

    // reset while held: no key_up, then a fresh key_down
    key_raw = 2'b01; w(7);
    chk("t6_held", key_level, 2'b01);
    reset = 1'b1; w(1);
    chk("t6_rst_level", key_level, 2'b00);
    chk("t6_rst_up",    key_up,    2'b00);
    chk("t6_rst_down",  key_down,  2'b00);
    reset = 1'b0; w(5);
    chk("t6_early_down", key_down, 2'b00);
    w(1);
    chk("t6_down", key_down, 2'b01);
    key_raw = 2'b00; w(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
